control_sequencer: RTL and testbench

Hardwired control unit that drives the ARC-style datapath's register-select, ALU and memory-strobe controls, and consumes its status outputs (decoded opcode, IR bit 13, condition code, flags). It runs fetch, decode and execute for a subset of ARC instructions, one FSM state per datapath micro-step, and handshakes with memory through a read/write strobe and a ready input. It sits between instruction memory/data memory and the datapath, at top level beside it.

---
 rtl/control_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute FSM for the ARC-style
// datapath. It drives register selects, ALU op and memory strobes, and
// handshakes with memory through RD/WR and MemReady.
// Optional build macro CONTROL_SEQUENCER_ILLEGAL_TRAP_EN: illegal opcodes
// trap to HALT with a sticky Error flag. Without it, they execute as NOPs.
module control_sequencer #(
  parameter int DATAWIDTH_SELECTION     = 6,
  parameter int DATAWIDTH_DECODEROP     = 8,
  parameter int DATAWIDTH_ALU_SELECTION = 4,
  parameter logic [DATAWIDTH_SELECTION-1:0] ADDR_PC    = DATAWIDTH_SELECTION'(32),
  parameter logic [DATAWIDTH_SELECTION-1:0] ADDR_IR    = DATAWIDTH_SELECTION'(33),
  parameter logic [DATAWIDTH_SELECTION-1:0] ADDR_TEMP0 = DATAWIDTH_SELECTION'(34)
) (
  input  logic                               CONTROL_SEQUENCER_CLOCK_50,
  input  logic                               CONTROL_SEQUENCER_ResetInLow_In,
  input  logic [DATAWIDTH_DECODEROP-1:0]     CONTROL_SEQUENCER_DecodeOP_InBus,
  input  logic                               CONTROL_SEQUENCER_IR13_In,
  input  logic                               CONTROL_SEQUENCER_ConditionCode_In,
  input  logic                               CONTROL_SEQUENCER_MemReady_In,
  output logic [DATAWIDTH_SELECTION-1:0]     CONTROL_SEQUENCER_DirA_OutBus,
  output logic [DATAWIDTH_SELECTION-1:0]     CONTROL_SEQUENCER_DirB_OutBus,
  output logic [DATAWIDTH_SELECTION-1:0]     CONTROL_SEQUENCER_DirC_OutBus,
  output logic                               CONTROL_SEQUENCER_SelectA_Out,
  output logic                               CONTROL_SEQUENCER_SelectB_Out,
  output logic                               CONTROL_SEQUENCER_SelectC_Out,
  output logic [DATAWIDTH_ALU_SELECTION-1:0] CONTROL_SEQUENCER_ALUOp_OutBus,
  output logic                               CONTROL_SEQUENCER_MuxMem_Out,
  output logic                               CONTROL_SEQUENCER_RD_Out,
  output logic                               CONTROL_SEQUENCER_WR_Out,
  output logic [3:0]                         CONTROL_SEQUENCER_State_OutBus,
  output logic                               CONTROL_SEQUENCER_Error_Out
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_SIMM    = 4'd2;
  localparam logic [3:0] S_ALU     = 4'd3;
  localparam logic [3:0] S_ADDR    = 4'd4;
  localparam logic [3:0] S_LOAD    = 4'd5;
  localparam logic [3:0] S_STORE   = 4'd6;
  localparam logic [3:0] S_BRANCH  = 4'd7;
  localparam logic [3:0] S_BRTAKE1 = 4'd8;
  localparam logic [3:0] S_BRTAKE2 = 4'd9;
  localparam logic [3:0] S_PCINC   = 4'd10;
  localparam logic [3:0] S_HALT    = 4'd15;

  localparam logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_ANDCC   = 4'b0000;
  localparam logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_ORCC    = 4'b0001;
  localparam logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_ORNCC   = 4'b0010;
  localparam logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_ADDCC   = 4'b0011;
  localparam logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_SRL     = 4'b0100;
  localparam logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_ADD     = 4'b1000;
  localparam logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_LSHIFT2 = 4'b1001;
  localparam logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_SEXT13  = 4'b1100;
  localparam logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_INCPC   = 4'b1110;

  localparam logic [DATAWIDTH_SELECTION-1:0] DIR_NONE = '0;

  logic [3:0] state_q, state_d;
  logic       use_temp_q, use_temp_d;
  logic       mem_class_q, mem_class_d;

  logic [1:0] op;
  logic [5:0] op3;
  logic [2:0] op2;
  logic       is_alu, is_mem, is_br, is_illegal;
  logic       rd_raw, wr_raw;

  // Instruction classification from the opcode fields of the current IR
  always_comb begin
    op     = CONTROL_SEQUENCER_DecodeOP_InBus[7:6];
    op3    = CONTROL_SEQUENCER_DecodeOP_InBus[5:0];
    op2    = CONTROL_SEQUENCER_DecodeOP_InBus[2:0];
    is_alu = (op == 2'b10) &&
             ((op3 == 6'b010000) || (op3 == 6'b010001) || (op3 == 6'b010010) ||
              (op3 == 6'b010110) || (op3 == 6'b100110));
    is_mem = (op == 2'b11) && ((op3 == 6'b000000) || (op3 == 6'b000100));
    is_br  = (op == 2'b00) && (op2 == 3'b010);
    is_illegal = !(is_alu || is_mem || is_br);
  end

  function automatic logic [DATAWIDTH_ALU_SELECTION-1:0] alu_sel(input logic [5:0] f3);
    case (f3)
      6'b010000: alu_sel = ALU_ADDCC;
      6'b010001: alu_sel = ALU_ANDCC;
      6'b010010: alu_sel = ALU_ORCC;
      6'b010110: alu_sel = ALU_ORNCC;
      6'b100110: alu_sel = ALU_SRL;
      default:   alu_sel = ALU_ADD;
    endcase
  endfunction

  // Next-state, operand-source flag and instruction-class bookkeeping
  always_comb begin
    state_d     = state_q;
    use_temp_d  = use_temp_q;
    mem_class_d = mem_class_q;
    case (state_q)
      S_FETCH:  if (CONTROL_SEQUENCER_MemReady_In) state_d = S_DECODE;
      S_DECODE: begin
        mem_class_d = is_mem;
        if (is_alu)      state_d = CONTROL_SEQUENCER_IR13_In ? S_SIMM : S_ALU;
        else if (is_mem) state_d = CONTROL_SEQUENCER_IR13_In ? S_SIMM : S_ADDR;
        else if (is_br)  state_d = S_BRANCH;
        else begin
`ifdef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          state_d = S_PCINC;
`endif
        end
      end
      S_SIMM: begin
        use_temp_d = 1'b1;
        state_d    = mem_class_q ? S_ADDR : S_ALU;
      end
      S_ALU:     state_d = S_PCINC;
      S_ADDR:    state_d = (op3 == 6'b000000) ? S_LOAD : S_STORE;
      S_LOAD:    if (CONTROL_SEQUENCER_MemReady_In) state_d = S_PCINC;
      S_STORE:   if (CONTROL_SEQUENCER_MemReady_In) state_d = S_PCINC;
      S_BRANCH:  state_d = CONTROL_SEQUENCER_ConditionCode_In ? S_BRTAKE1 : S_PCINC;
      S_BRTAKE1: state_d = S_BRTAKE2;
      S_BRTAKE2: state_d = S_FETCH;
      S_PCINC: begin
        use_temp_d = 1'b0;
        state_d    = S_FETCH;
      end
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
  end

  // State and flag registers, cleared asynchronously by the low reset
  always_ff @(posedge CONTROL_SEQUENCER_CLOCK_50 or negedge CONTROL_SEQUENCER_ResetInLow_In) begin
    if (!CONTROL_SEQUENCER_ResetInLow_In) begin
      state_q     <= S_FETCH;
      use_temp_q  <= 1'b0;
      mem_class_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      use_temp_q  <= use_temp_d;
      mem_class_q <= mem_class_d;
    end
  end

`ifdef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
  logic error_q, error_d;

  // Sticky illegal-opcode flag, only reset clears it
  always_comb begin
    error_d = error_q | ((state_q == S_DECODE) && is_illegal);
  end

  // Error flag register
  always_ff @(posedge CONTROL_SEQUENCER_CLOCK_50 or negedge CONTROL_SEQUENCER_ResetInLow_In) begin
    if (!CONTROL_SEQUENCER_ResetInLow_In) error_q <= 1'b0;
    else                                  error_q <= error_d;
  end

  assign CONTROL_SEQUENCER_Error_Out = error_q;
`else
  logic unused_illegal;
  assign unused_illegal              = is_illegal;
  assign CONTROL_SEQUENCER_Error_Out = 1'b0;
`endif

  // Moore output decode from the registered state
  always_comb begin
    CONTROL_SEQUENCER_DirA_OutBus  = DIR_NONE;
    CONTROL_SEQUENCER_DirB_OutBus  = DIR_NONE;
    CONTROL_SEQUENCER_DirC_OutBus  = DIR_NONE;
    CONTROL_SEQUENCER_SelectA_Out  = 1'b1;
    CONTROL_SEQUENCER_SelectB_Out  = 1'b1;
    CONTROL_SEQUENCER_SelectC_Out  = 1'b1;
    CONTROL_SEQUENCER_ALUOp_OutBus = ALU_ADD;
    CONTROL_SEQUENCER_MuxMem_Out   = 1'b0;
    rd_raw                         = 1'b0;
    wr_raw                         = 1'b0;
    case (state_q)
      S_FETCH: begin
        CONTROL_SEQUENCER_DirA_OutBus = ADDR_PC;
        CONTROL_SEQUENCER_DirC_OutBus = ADDR_IR;
        CONTROL_SEQUENCER_MuxMem_Out  = 1'b1;
        rd_raw                        = 1'b1;
      end
      S_SIMM: begin
        CONTROL_SEQUENCER_DirB_OutBus  = ADDR_IR;
        CONTROL_SEQUENCER_DirC_OutBus  = ADDR_TEMP0;
        CONTROL_SEQUENCER_ALUOp_OutBus = ALU_SEXT13;
      end
      S_ALU: begin
        CONTROL_SEQUENCER_SelectA_Out  = 1'b0;
        CONTROL_SEQUENCER_SelectB_Out  = use_temp_q;
        CONTROL_SEQUENCER_DirB_OutBus  = use_temp_q ? ADDR_TEMP0 : DIR_NONE;
        CONTROL_SEQUENCER_SelectC_Out  = 1'b0;
        CONTROL_SEQUENCER_ALUOp_OutBus = alu_sel(op3);
      end
      S_ADDR: begin
        CONTROL_SEQUENCER_SelectA_Out = 1'b0;
        CONTROL_SEQUENCER_SelectB_Out = use_temp_q;
        CONTROL_SEQUENCER_DirB_OutBus = use_temp_q ? ADDR_TEMP0 : DIR_NONE;
        CONTROL_SEQUENCER_DirC_OutBus = ADDR_TEMP0;
      end
      S_LOAD: begin
        CONTROL_SEQUENCER_DirA_OutBus = ADDR_TEMP0;
        CONTROL_SEQUENCER_SelectC_Out = 1'b0;
        CONTROL_SEQUENCER_MuxMem_Out  = 1'b1;
        rd_raw                        = 1'b1;
      end
      S_STORE: begin
        CONTROL_SEQUENCER_DirA_OutBus = ADDR_TEMP0;
        CONTROL_SEQUENCER_SelectB_Out = 1'b0;
        wr_raw                        = 1'b1;
      end
      S_BRTAKE1: begin
        CONTROL_SEQUENCER_DirB_OutBus  = ADDR_IR;
        CONTROL_SEQUENCER_DirC_OutBus  = ADDR_TEMP0;
        CONTROL_SEQUENCER_ALUOp_OutBus = ALU_LSHIFT2;
      end
      S_BRTAKE2: begin
        CONTROL_SEQUENCER_DirA_OutBus = ADDR_PC;
        CONTROL_SEQUENCER_DirB_OutBus = ADDR_TEMP0;
        CONTROL_SEQUENCER_DirC_OutBus = ADDR_PC;
      end
      S_PCINC: begin
        CONTROL_SEQUENCER_DirA_OutBus  = ADDR_PC;
        CONTROL_SEQUENCER_DirC_OutBus  = ADDR_PC;
        CONTROL_SEQUENCER_ALUOp_OutBus = ALU_INCPC;
      end
      S_HALT:  ;
      default: ;
    endcase
  end

  // Strobes drop the moment reset is asserted, without waiting for a clock
  assign CONTROL_SEQUENCER_RD_Out       = rd_raw & CONTROL_SEQUENCER_ResetInLow_In;
  assign CONTROL_SEQUENCER_WR_Out       = wr_raw & CONTROL_SEQUENCER_ResetInLow_In;
  assign CONTROL_SEQUENCER_State_OutBus = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: expected per-cycle output vectors are
// queued per scenario and popped as the DUT steps through its states.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] dec_op;
  logic       ir13, cc, mem_rdy;
  logic [5:0] dira, dirb, dirc;
  logic       sela, selb, selc, muxmem, rd, wr, err;
  logic [3:0] aluop, state;

  typedef struct packed {
    logic [3:0] st;
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] c;
    logic       sa;
    logic       sb;
    logic       sc;
    logic [3:0] alu;
    logic       mm;
    logic       rd;
    logic       wr;
    logic       er;
  } exp_t;

  exp_t obs;
  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  control_sequencer dut (
    .CONTROL_SEQUENCER_CLOCK_50        (clk),
    .CONTROL_SEQUENCER_ResetInLow_In   (rst_n),
    .CONTROL_SEQUENCER_DecodeOP_InBus  (dec_op),
    .CONTROL_SEQUENCER_IR13_In         (ir13),
    .CONTROL_SEQUENCER_ConditionCode_In(cc),
    .CONTROL_SEQUENCER_MemReady_In     (mem_rdy),
    .CONTROL_SEQUENCER_DirA_OutBus     (dira),
    .CONTROL_SEQUENCER_DirB_OutBus     (dirb),
    .CONTROL_SEQUENCER_DirC_OutBus     (dirc),
    .CONTROL_SEQUENCER_SelectA_Out     (sela),
    .CONTROL_SEQUENCER_SelectB_Out     (selb),
    .CONTROL_SEQUENCER_SelectC_Out     (selc),
    .CONTROL_SEQUENCER_ALUOp_OutBus    (aluop),
    .CONTROL_SEQUENCER_MuxMem_Out      (muxmem),
    .CONTROL_SEQUENCER_RD_Out          (rd),
    .CONTROL_SEQUENCER_WR_Out          (wr),
    .CONTROL_SEQUENCER_State_OutBus    (state),
    .CONTROL_SEQUENCER_Error_Out       (err)
  );

  always #5 clk = ~clk;

  assign obs = {state, dira, dirb, dirc, sela, selb, selc, aluop, muxmem, rd, wr, err};

  // Expected output vectors per state, written out from the state table
  function automatic exp_t mk(logic [3:0] st, logic [5:0] a, logic [5:0] b, logic [5:0] c,
                              logic s_a, logic s_b, logic s_c, logic [3:0] alu,
                              logic mm, logic r, logic w, logic e);
    mk = {st, a, b, c, s_a, s_b, s_c, alu, mm, r, w, e};
  endfunction
  function automatic exp_t x_fetch(logic r, logic e);
    x_fetch = mk(4'd0, 6'd32, 6'd0, 6'd33, 1, 1, 1, 4'b1000, 1, r, 0, e);
  endfunction
  function automatic exp_t x_decode();
    x_decode = mk(4'd1, 6'd0, 6'd0, 6'd0, 1, 1, 1, 4'b1000, 0, 0, 0, 0);
  endfunction
  function automatic exp_t x_simm();
    x_simm = mk(4'd2, 6'd0, 6'd33, 6'd34, 1, 1, 1, 4'b1100, 0, 0, 0, 0);
  endfunction
  function automatic exp_t x_alu(logic [3:0] alu, logic ut);
    x_alu = mk(4'd3, 6'd0, ut ? 6'd34 : 6'd0, 6'd0, 0, ut, 0, alu, 0, 0, 0, 0);
  endfunction
  function automatic exp_t x_addr(logic ut);
    x_addr = mk(4'd4, 6'd0, ut ? 6'd34 : 6'd0, 6'd34, 0, ut, 1, 4'b1000, 0, 0, 0, 0);
  endfunction
  function automatic exp_t x_load();
    x_load = mk(4'd5, 6'd34, 6'd0, 6'd0, 1, 1, 0, 4'b1000, 1, 1, 0, 0);
  endfunction
  function automatic exp_t x_store();
    x_store = mk(4'd6, 6'd34, 6'd0, 6'd0, 1, 0, 1, 4'b1000, 0, 0, 1, 0);
  endfunction
  function automatic exp_t x_branch();
    x_branch = mk(4'd7, 6'd0, 6'd0, 6'd0, 1, 1, 1, 4'b1000, 0, 0, 0, 0);
  endfunction
  function automatic exp_t x_brt1();
    x_brt1 = mk(4'd8, 6'd0, 6'd33, 6'd34, 1, 1, 1, 4'b1001, 0, 0, 0, 0);
  endfunction
  function automatic exp_t x_brt2();
    x_brt2 = mk(4'd9, 6'd32, 6'd34, 6'd32, 1, 1, 1, 4'b1000, 0, 0, 0, 0);
  endfunction
  function automatic exp_t x_pcinc();
    x_pcinc = mk(4'd10, 6'd32, 6'd0, 6'd32, 1, 1, 1, 4'b1110, 0, 0, 0, 0);
  endfunction
  function automatic exp_t x_halt();
    x_halt = mk(4'd15, 6'd0, 6'd0, 6'd0, 1, 1, 1, 4'b1000, 0, 0, 0, 1);
  endfunction

  // RD and WR must never be asserted together
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rd === 1'b1 && wr === 1'b1) begin
      miscompares++;
      $display("FAIL rd_wr_exclusive t=%0t rd=%b wr=%b required not both 1", $time, rd, wr);
    end
  end

  task automatic test_reset();
    exp_t e;
    sb.push_back(x_fetch(0, 0));
    sb.push_back(x_fetch(1, 0));
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      mem_rdy = 1'b0;
      #1;
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL reset cyc%0d got %h want %h", i, obs, e);
      end
      if (i == 0) rst_n = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_alu_reg();
    exp_t e;
    int n;
    sb.push_back(x_fetch(1, 0)); sb.push_back(x_decode());
    sb.push_back(x_alu(4'b0011, 0)); sb.push_back(x_pcinc()); sb.push_back(x_fetch(1, 0));
    n = sb.size();
    dec_op = 8'b10_010000; ir13 = 1'b0; cc = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_rdy = (i == n - 1) ? 1'b0 : 1'b1;
      #1;
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL alu_reg cyc%0d got %h want %h", i, obs, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_alu_ops();
    logic [7:0] ops [4];
    logic [3:0] alus [4];
    exp_t e;
    ops[0] = 8'b10_010001; alus[0] = 4'b0000;
    ops[1] = 8'b10_010010; alus[1] = 4'b0001;
    ops[2] = 8'b10_010110; alus[2] = 4'b0010;
    ops[3] = 8'b10_100110; alus[3] = 4'b0100;
    ir13 = 1'b0; cc = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dec_op = ops[k];
      sb.push_back(x_fetch(1, 0)); sb.push_back(x_decode());
      sb.push_back(x_alu(alus[k], 0)); sb.push_back(x_pcinc());
      for (int i = 0; i < 4; i++) begin
        mem_rdy = 1'b1;
        #1;
        e = sb.pop_front();
        vectors++;
        if (obs !== e) begin
          miscompares++;
          $display("FAIL alu_ops op=%h cyc%0d got %h want %h", ops[k], i, obs, e);
        end
        @(negedge clk);
      end
    end
    sb.push_back(x_fetch(1, 0));
    mem_rdy = 1'b0;
    #1;
    e = sb.pop_front();
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL alu_ops_end got %h want %h", obs, e);
    end
    @(negedge clk);
  endtask

  task automatic test_alu_simm();
    exp_t e;
    int n;
    sb.push_back(x_fetch(1, 0)); sb.push_back(x_decode()); sb.push_back(x_simm());
    sb.push_back(x_alu(4'b0011, 1)); sb.push_back(x_pcinc()); sb.push_back(x_fetch(1, 0));
    n = sb.size();
    dec_op = 8'b10_010000; ir13 = 1'b1; cc = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_rdy = (i == n - 1) ? 1'b0 : 1'b1;
      #1;
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL alu_simm cyc%0d got %h want %h", i, obs, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_wait();
    exp_t e;
    int n;
    sb.push_back(x_fetch(1, 0)); sb.push_back(x_decode()); sb.push_back(x_addr(0));
    for (int i = 0; i < 4; i++) sb.push_back(x_load());
    sb.push_back(x_pcinc()); sb.push_back(x_fetch(1, 0));
    n = sb.size();
    dec_op = 8'b11_000000; ir13 = 1'b0; cc = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_rdy = (i == 0 || i == 6) ? 1'b1 : 1'b0;
      #1;
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL load_wait cyc%0d got %h want %h", i, obs, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_simm();
    exp_t e;
    int n;
    sb.push_back(x_fetch(1, 0)); sb.push_back(x_decode()); sb.push_back(x_simm());
    sb.push_back(x_addr(1)); sb.push_back(x_load()); sb.push_back(x_pcinc());
    sb.push_back(x_fetch(1, 0));
    n = sb.size();
    dec_op = 8'b11_000000; ir13 = 1'b1; cc = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_rdy = (i == n - 1) ? 1'b0 : 1'b1;
      #1;
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL load_simm cyc%0d got %h want %h", i, obs, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_store();
    exp_t e;
    int n;
    sb.push_back(x_fetch(1, 0)); sb.push_back(x_fetch(1, 0)); sb.push_back(x_fetch(1, 0));
    sb.push_back(x_decode()); sb.push_back(x_addr(0)); sb.push_back(x_store());
    sb.push_back(x_pcinc()); sb.push_back(x_fetch(1, 0));
    n = sb.size();
    dec_op = 8'b11_000100; ir13 = 1'b0; cc = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_rdy = (i == 2 || i == 5) ? 1'b1 : 1'b0;
      #1;
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL store cyc%0d got %h want %h", i, obs, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch(input logic taken);
    exp_t e;
    int n;
    sb.push_back(x_fetch(1, 0)); sb.push_back(x_decode()); sb.push_back(x_branch());
    if (taken) begin
      sb.push_back(x_brt1()); sb.push_back(x_brt2());
    end else begin
      sb.push_back(x_pcinc());
    end
    sb.push_back(x_fetch(1, 0));
    n = sb.size();
    dec_op = 8'b00_000010; ir13 = 1'b0; cc = taken;
    for (int i = 0; i < n; i++) begin
      mem_rdy = (i == n - 1) ? 1'b0 : 1'b1;
      #1;
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL branch taken=%b cyc%0d got %h want %h", taken, i, obs, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    int n;
    sb.push_back(x_fetch(1, 0)); sb.push_back(x_decode());
`ifdef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
    sb.push_back(x_halt()); sb.push_back(x_halt()); sb.push_back(x_halt());
`else
    sb.push_back(x_pcinc()); sb.push_back(x_fetch(1, 0));
`endif
    sb.push_back(x_fetch(0, 0));
    n = sb.size();
    dec_op = 8'hFF; ir13 = 1'b0; cc = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_rdy = (i == 0 || i == 2) ? 1'b1 : 1'b0;
      if (i == 3) dec_op = 8'b10_010000;
      if (i == n - 1) rst_n = 1'b0;
      #1;
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL illegal cyc%0d got %h want %h", i, obs, e);
      end
      if (i == n - 1) rst_n = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midop();
    exp_t e;
    int n;
    sb.push_back(x_fetch(1, 0)); sb.push_back(x_decode()); sb.push_back(x_addr(0));
    sb.push_back(x_store()); sb.push_back(x_fetch(0, 0)); sb.push_back(x_fetch(1, 0));
    n = sb.size();
    dec_op = 8'b11_000100; ir13 = 1'b0; cc = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_rdy = (i == 0) ? 1'b1 : 1'b0;
      if (i == 4) begin
        #2;
        rst_n = 1'b0;
      end
      #1;
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL reset_midop cyc%0d got %h want %h", i, obs, e);
      end
      if (i == 4) rst_n = 1'b1;
      if (i != 3) @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; dec_op = 8'h00; ir13 = 1'b0; cc = 1'b0; mem_rdy = 1'b0;
    test_reset();
    test_alu_reg();
    test_alu_ops();
    test_alu_simm();
    test_load_wait();
    test_load_simm();
    test_store();
    test_branch(1'b1);
    test_branch(1'b0);
    test_illegal();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
